// File: rtl/capture_bank_buffer_if.sv
// capture_bank_buffer_if: bundle of the capture-stage inputs and the sample-stream outputs.
// Revision 1.0
`default_nettype none

interface capture_bank_buffer_if #(
    parameter int WIDTH = 24,
    parameter int SBITS = 8
);
    logic                   enable_i;
    logic                   clear_i;
    logic [WIDTH-1:0]       strobe_i;
    logic [WIDTH-1:0]       locked_i;
    logic [WIDTH-1:0]       invalid_i;
    logic [WIDTH-1:0]       signal_i;
    logic                   retry_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [WIDTH+SBITS-1:0] data_o;
    logic [1:0]             state_o;
    logic                   overflow_o;
    logic                   fault_o;

    modport slave (
        input  enable_i, clear_i, strobe_i, locked_i, invalid_i, signal_i, ready_i,
        output retry_o, valid_o, data_o, state_o, overflow_o, fault_o
    );

    modport master (
        output enable_i, clear_i, strobe_i, locked_i, invalid_i, signal_i, ready_i,
        input  retry_o, valid_o, data_o, state_o, overflow_o, fault_o
    );
endinterface

`default_nettype wire

// File: rtl/capture_bank_buffer.sv
// capture_bank_buffer: packs coincident antenna captures into sequence-tagged words and queues them in a FIFO.
// Revision 1.0
`default_nettype none

module capture_bank_buffer #(
    parameter int WIDTH = 24,
    parameter int ABITS = 3,
    parameter int SBITS = 8,
    parameter int DELAY = 3
) (
    input  wire logic              clock_i,
    input  wire logic              reset_i,
    capture_bank_buffer_if.slave   bus
);
    localparam int DEPTH = 2 ** ABITS;
    localparam int DW    = WIDTH + SBITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [ABITS:0] FULL_COUNT = (ABITS + 1)'(DEPTH);

    // Register delay is a simulation-only notion with no synthesizable meaning here.
    logic [31:0] unused_delay;
    assign unused_delay = 32'(DELAY);

    logic [1:0]       state_q,    state_d;
    logic [SBITS-1:0] seq_q,      seq_d;
    logic [ABITS:0]   count_q,    count_d;
    logic [ABITS-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q,   rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             fault_q,    fault_d;
    logic             retry_q,    retry_d;
    logic [DW-1:0]    mem_q [DEPTH];

    logic strb, skew, lock_all, fault_cond;
    logic push_req, push_ok, pop, full, enter_fault;

    always_comb begin
        strb        = &bus.strobe_i;
        skew        = (|bus.strobe_i) && !strb;
        lock_all    = &bus.locked_i;
        fault_cond  = (|bus.invalid_i) || skew || !lock_all;
        full        = (count_q == FULL_COUNT);
        pop         = (count_q != '0) && bus.ready_i;
        enter_fault = (state_q == ST_RUN) && bus.enable_i && fault_cond;
        push_req    = (state_q == ST_RUN) && bus.enable_i && !fault_cond && strb && !bus.clear_i;
        push_ok     = push_req && (!full || pop);

        state_d = state_q;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE:  if (bus.enable_i) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!bus.enable_i) begin
                    state_d = ST_IDLE;
                end else if (lock_all && strb) begin
                    // The locking strobe only aligns the bank; its sample is not kept.
                    state_d = ST_RUN;
                    seq_d   = '0;
                end
            end
            ST_RUN: begin
                if (!bus.enable_i) state_d = ST_IDLE;
                else if (fault_cond) state_d = ST_FAULT;
            end
            default:  if (bus.clear_i) state_d = bus.enable_i ? ST_WAIT : ST_IDLE;
        endcase

        // Dropped words still consume a sequence number so the gap is visible downstream.
        if (push_req) seq_d = seq_q + 1'b1;

        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (push_ok ? 1'b1 : 1'b0) - (pop ? 1'b1 : 1'b0);
        overflow_d = overflow_q || (push_req && full && !pop);
        fault_d    = fault_q;
        retry_d    = enter_fault;

        if (bus.clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            fault_d    = 1'b0;
        end
        if (enter_fault) fault_d = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            seq_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
            retry_q    <= retry_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= {seq_q, bus.signal_i};
    end

    assign bus.valid_o    = (count_q != '0);
    assign bus.data_o     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.state_o    = state_q;
    assign bus.overflow_o = overflow_q;
    assign bus.fault_o    = fault_q;
    assign bus.retry_o    = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_bank_buffer.sv
// tb_capture_bank_buffer: directed stimulus with a queue-based reference model checked every cycle.
// Revision 1.0
`default_nettype none

module tb_capture_bank_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    capture_bank_buffer_if #(.WIDTH(24), .SBITS(8)) bus ();

    capture_bank_buffer #(.WIDTH(24), .ABITS(3), .SBITS(8), .DELAY(3)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 waiting for lock, 2 running, 3 faulted.
    logic [31:0] m_q[$];
    int          m_mode = 0;
    int          m_seq  = 0;
    bit          m_ovf, m_fault, m_retry;
    bit          all_s, any_s, bad_s, want_push, enter, popped;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_seq = 0; m_ovf = 0; m_fault = 0; m_retry = 0;
        end else begin
            all_s  = (bus.strobe_i == 24'hFFFFFF);
            any_s  = (bus.strobe_i != 24'h0);
            bad_s  = (bus.invalid_i != 24'h0) || (any_s && !all_s) || (bus.locked_i != 24'hFFFFFF);
            popped = bus.ready_i && (m_q.size() > 0);
            want_push = 0; enter = 0; m_retry = 0;
            case (m_mode)
                0: if (bus.enable_i) m_mode = 1;
                1: if (!bus.enable_i) m_mode = 0;
                   else if (bus.locked_i == 24'hFFFFFF && all_s) begin m_mode = 2; m_seq = 0; end
                2: if (!bus.enable_i) m_mode = 0;
                   else if (bad_s) begin m_mode = 3; enter = 1; m_retry = 1; end
                   else if (all_s) want_push = 1;
                default: if (bus.clear_i) m_mode = bus.enable_i ? 1 : 0;
            endcase
            if (popped) void'(m_q.pop_front());
            if (bus.clear_i) begin
                m_q.delete(); m_ovf = 0; m_fault = 0;
            end else if (want_push) begin
                if (m_q.size() < 8) m_q.push_back({m_seq[7:0], bus.signal_i});
                else m_ovf = 1;
                m_seq = (m_seq + 1) % 256;
            end
            if (enter) m_fault = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("state", 64'(bus.state_o), 64'(m_mode));
            check("valid", 64'(bus.valid_o), 64'(m_q.size() != 0));
            if (m_q.size() != 0) check("data", 64'(bus.data_o), 64'(m_q[0]));
            check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
            check("fault", 64'(bus.fault_o), 64'(m_fault));
            check("retry", 64'(bus.retry_o), 64'(m_retry));
        end
    end

    task automatic do_strobe(input logic [23:0] sig);
        bus.strobe_i = 24'hFFFFFF;
        bus.signal_i = sig;
        @(negedge clk);
        bus.strobe_i = 24'h0;
    endtask

    task automatic drain(input string name, input int exp_n);
        int n = 0;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!bus.valid_o) break;
            n++;
            @(negedge clk);
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    logic [23:0] pats [3] = '{24'hA5A5A5, 24'h5A5A5A, 24'h3C3C3C};

    initial begin
        bus.enable_i = 0; bus.clear_i = 0; bus.strobe_i = 0; bus.locked_i = 0;
        bus.invalid_i = 0; bus.signal_i = 0; bus.ready_i = 1;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(bus.state_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_flags", 64'({bus.overflow_o, bus.fault_o, bus.retry_o}), 64'd0);
        rst = 0;

        // Lock-up and first three samples
        bus.enable_i = 1; bus.locked_i = 24'hFFFFFF;
        @(negedge clk);
        check("to_wait", 64'(bus.state_o), 64'd1);
        do_strobe(24'h111111);
        check("to_run", 64'(bus.state_o), 64'd2);
        check("lock_nopush", 64'(bus.valid_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            repeat (11) @(negedge clk);
            do_strobe(pats[i]);
            check("lock_valid", 64'(bus.valid_o), 64'd1);
            check("lock_data", 64'(bus.data_o), 64'({i[7:0], pats[i]}));
        end
        check("lit_seq2", 64'(bus.data_o), 64'h023C3C3C);

        // Backpressure and overflow from a fresh sequence
        bus.enable_i = 0; @(negedge clk);
        bus.enable_i = 1; @(negedge clk);
        do_strobe(24'h0);
        bus.ready_i = 0;
        for (int i = 0; i < 10; i++) begin
            do_strobe(24'hC00000 | 24'(i));
            @(negedge clk);
        end
        check("ovf_set", 64'(bus.overflow_o), 64'd1);
        check("ovf_head", 64'(bus.data_o), 64'h00C00000);
        drain("ovf_drain", 8);
        do_strobe(24'hDEADBE);
        check("seq_gap", 64'(bus.data_o), 64'h0ADEADBE);
        @(negedge clk);

        // Full FIFO with a pop in the strobe cycle
        bus.clear_i = 1; @(negedge clk); bus.clear_i = 0;
        check("clr_ovf", 64'(bus.overflow_o), 64'd0);
        bus.ready_i = 0;
        for (int i = 0; i < 8; i++) do_strobe(24'h400000 | 24'(i));
        bus.ready_i = 1;
        do_strobe(24'h4000FF);
        bus.ready_i = 0;
        check("full_pop_ovf", 64'(bus.overflow_o), 64'd0);
        check("full_pop_head", 64'(bus.data_o), 64'h0C400001);
        drain("full_pop_drain", 8);

        // Invalid flag during a strobe
        bus.invalid_i = 24'h000020;
        do_strobe(24'h777777);
        bus.invalid_i = 0;
        check("flt_state", 64'(bus.state_o), 64'd3);
        check("flt_flag", 64'(bus.fault_o), 64'd1);
        check("flt_retry", 64'(bus.retry_o), 64'd1);
        check("flt_nopush", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        check("flt_retry_off", 64'(bus.retry_o), 64'd0);
        bus.clear_i = 1; @(negedge clk); bus.clear_i = 0;
        check("flt_clr_state", 64'(bus.state_o), 64'd1);
        check("flt_clr_flag", 64'(bus.fault_o), 64'd0);

        // Non-coincident strobes
        do_strobe(24'h0);
        bus.strobe_i = 24'h000001; @(negedge clk); bus.strobe_i = 0;
        check("skew_state", 64'(bus.state_o), 64'd3);
        check("skew_nopush", 64'(bus.valid_o), 64'd0);
        bus.clear_i = 1; @(negedge clk); bus.clear_i = 0;

        // Asynchronous reset while a word is waiting
        do_strobe(24'h0);
        bus.ready_i = 0;
        do_strobe(24'h123456);
        check("pre_rst_data", 64'(bus.data_o), 64'h00123456);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_valid", 64'(bus.valid_o), 64'd0);
        check("arst_state", 64'(bus.state_o), 64'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("arst_data", 64'(bus.data_o), 64'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
